// File: rtl/btc_nonce_feeder_checker.sv
// Feeds nonces into a fixed-latency, free-running SHA-256 pipeline and checks the returned
// hash word; matching nonces are queued in a small FIFO for host readout.
module btc_nonce_feeder_checker #(
  parameter int unsigned LATENCY     = 66,
  parameter logic [31:0] MATCH_VALUE = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic        restart,
  input  logic [31:0] nonce_start,
  output logic [31:0] nonce_out,
  input  logic [31:0] hash_in,
  output logic        gn_valid,
  output logic [31:0] gn_nonce,
  input  logic        gn_ready,
  output logic [7:0]  overflow_cnt,
  output logic [31:0] checked_cnt
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]        nonce_q, nonce_d;
  logic [31:0]        chk_nonce_q, chk_nonce_d;
  logic [LATENCY-1:0] vld_sr_q, vld_sr_d;
  logic [LATENCY:0]   vld_shift;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [7:0]         ovf_q, ovf_d;
  logic [31:0]        checked_q, checked_d;
  logic [31:0]        mem_q [FIFO_DEPTH];

  logic issue, tap, push, pop, full, wr_en;

  always_comb begin
    issue     = run & ~restart;
    tap       = vld_sr_q[LATENCY-1];
    // Extra bit lets LATENCY == 1 use the same slice expression.
    vld_shift = {vld_sr_q, issue};
    vld_sr_d  = restart ? '0 : vld_shift[LATENCY-1:0];

    nonce_d = nonce_q;
    if (restart) begin
      nonce_d = nonce_start;
    end else if (run) begin
      nonce_d = nonce_q + 32'd1;
    end

    chk_nonce_d = chk_nonce_q;
    if (restart) begin
      chk_nonce_d = nonce_start;
    end else if (tap) begin
      chk_nonce_d = chk_nonce_q + 32'd1;
    end

    checked_d = restart ? '0 : checked_q + 32'(tap);

    push  = tap & (hash_in == MATCH_VALUE) & ~restart;
    full  = (count_q == CntW'(FIFO_DEPTH));
    pop   = (count_q != '0) & gn_ready;
    // A pop frees the head slot in the same cycle, so a push into a full FIFO still lands.
    wr_en = push & (~full | pop);

    wr_ptr_d = wr_ptr_q + PtrW'(wr_en);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    count_d  = count_q + CntW'(wr_en) - CntW'(pop);

    ovf_d = ovf_q;
    if (push && full && !pop && (ovf_q != 8'hFF)) begin
      ovf_d = ovf_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nonce_q     <= '0;
      chk_nonce_q <= '0;
      vld_sr_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= '0;
      checked_q   <= '0;
    end else begin
      nonce_q     <= nonce_d;
      chk_nonce_q <= chk_nonce_d;
      vld_sr_q    <= vld_sr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      checked_q   <= checked_d;
    end
  end

  // Storage is reset so gn_nonce reads zero straight out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= chk_nonce_q;
    end
  end

  always_comb begin
    nonce_out    = nonce_q;
    gn_valid     = (count_q != '0);
    gn_nonce     = mem_q[rd_ptr_q];
    overflow_cnt = ovf_q;
    checked_cnt  = checked_q;
  end

endmodule

// File: tb/tb_btc_nonce_feeder_checker.sv
// Bench for btc_nonce_feeder_checker: delay-line pipeline model, queue-based reference model
// compared every cycle, directed scenarios with literal expectations, then random traffic.
module tb_btc_nonce_feeder_checker;

  localparam int unsigned Lat   = 4;
  localparam int unsigned Depth = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic        restart = 1'b0;
  logic [31:0] nonce_start = '0;
  logic [31:0] nonce_out;
  logic [31:0] hash_in;
  logic        gn_valid;
  logic [31:0] gn_nonce;
  logic        gn_ready = 1'b0;
  logic [7:0]  overflow_cnt;
  logic [31:0] checked_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic match_all = 1'b0;

  btc_nonce_feeder_checker #(
    .LATENCY    (Lat),
    .MATCH_VALUE(32'h0000_0000),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .run         (run),
    .restart     (restart),
    .nonce_start (nonce_start),
    .nonce_out   (nonce_out),
    .hash_in     (hash_in),
    .gn_valid    (gn_valid),
    .gn_nonce    (gn_nonce),
    .gn_ready    (gn_ready),
    .overflow_cnt(overflow_cnt),
    .checked_cnt (checked_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic golden(input logic [31:0] n);
    return match_all || (n == 32'h105) || (n == 32'h10A);
  endfunction

  // Free-running pipeline: hash of whatever was on nonce_out Lat cycles ago.
  logic [31:0] pipe [Lat];
  always @(posedge clk) begin
    pipe[0] <= nonce_out;
    for (int i = 1; i < Lat; i++) pipe[i] <= pipe[i-1];
  end
  assign hash_in = golden(pipe[Lat-1]) ? 32'h0000_0000 : 32'hFFFF_FFFF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: list of in-flight nonces with the cycle their hash is due.
  typedef struct {
    logic [31:0] n;
    longint      due;
  } fl_t;
  fl_t         inflight[$];
  logic [31:0] m_fifo[$];
  logic [31:0] m_nonce = '0;
  logic [31:0] m_checked = '0;
  int          m_ovf = 0;
  longint      cyc = 0;
  fl_t         head;
  bit          m_pop, m_full;

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        inflight.delete();
        m_fifo.delete();
        m_nonce = '0;
        m_checked = '0;
        m_ovf = 0;
        cyc = 0;
      end else begin
        m_pop  = (m_fifo.size() > 0) && gn_ready;
        m_full = (m_fifo.size() == Depth);
        if (m_pop) void'(m_fifo.pop_front());
        if (inflight.size() > 0 && inflight[0].due == cyc) begin
          head = inflight.pop_front();
          if (!restart) begin
            m_checked = m_checked + 1;
            if (golden(head.n)) begin
              if (!m_full || m_pop) m_fifo.push_back(head.n);
              else if (m_ovf < 255) m_ovf++;
            end
          end
        end
        if (restart) begin
          inflight.delete();
          m_checked = '0;
          m_nonce = nonce_start;
        end else if (run) begin
          inflight.push_back('{n: m_nonce, due: cyc + Lat});
          m_nonce = m_nonce + 1;
        end
        cyc++;
      end
    end
  end

  // Per-cycle compare plus a log of accepted entries.
  logic [31:0] popped[$];
  int          valid_cycles = 0;
  initial begin
    forever begin
      @(negedge clk);
      chk("nonce_out", nonce_out, m_nonce);
      chk("gn_valid", {31'd0, gn_valid}, {31'd0, m_fifo.size() > 0});
      if (m_fifo.size() > 0) chk("gn_nonce", gn_nonce, m_fifo[0]);
      chk("overflow_cnt", {24'd0, overflow_cnt}, 32'(m_ovf));
      chk("checked_cnt", checked_cnt, m_checked);
      if (gn_valid) valid_cycles++;
      if (gn_valid && gn_ready) popped.push_back(gn_nonce);
    end
  end

  task automatic cyc_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_restart(input logic [31:0] start);
    restart = 1'b1;
    nonce_start = start;
    run = 1'b0;
    cyc_n(1);
    restart = 1'b0;
  endtask

  task automatic scen_basic(input string tag);
    int pb, vb;
    match_all = 1'b0;
    gn_ready = 1'b1;
    do_restart(32'h100);
    pb = popped.size();
    vb = valid_cycles;
    run = 1'b1;
    cyc_n(20);
    run = 1'b0;
    cyc_n(10);
    chk({tag, "_pop_count"}, 32'(popped.size() - pb), 32'd2);
    chk({tag, "_pop0"}, popped[pb], 32'h105);
    chk({tag, "_pop1"}, popped[pb+1], 32'h10A);
    chk({tag, "_valid_cycles"}, 32'(valid_cycles - vb), 32'd2);
    chk({tag, "_checked"}, checked_cnt, 32'd20);
    chk({tag, "_nonce_out"}, nonce_out, 32'h114);
  endtask

  int pb;

  initial begin
    cyc_n(2);
    chk("rst_nonce_out", nonce_out, 32'd0);
    chk("rst_gn_valid", {31'd0, gn_valid}, 32'd0);
    chk("rst_gn_nonce", gn_nonce, 32'd0);
    chk("rst_ovf", {24'd0, overflow_cnt}, 32'd0);
    chk("rst_checked", checked_cnt, 32'd0);
    reset_n = 1'b1;
    cyc_n(2);

    scen_basic("s1");

    // Pause: run alternates, each golden nonce reported once.
    do_restart(32'h100);
    pb = popped.size();
    for (int i = 0; i < 40; i++) begin
      run = (i % 2 == 0);
      cyc_n(1);
    end
    run = 1'b0;
    cyc_n(10);
    chk("s2_pop_count", 32'(popped.size() - pb), 32'd2);
    chk("s2_pop0", popped[pb], 32'h105);
    chk("s2_pop1", popped[pb+1], 32'h10A);
    chk("s2_checked", checked_cnt, 32'd20);

    // Restart mid-flight; an older entry stays queued.
    gn_ready = 1'b0;
    do_restart(32'h10A);
    run = 1'b1;
    cyc_n(1);
    run = 1'b0;
    cyc_n(8);
    pb = popped.size();
    do_restart(32'h100);
    run = 1'b1;
    cyc_n(8);
    restart = 1'b1;
    nonce_start = 32'h200;
    cyc_n(1);
    restart = 1'b0;
    chk("s3_checked_clr", checked_cnt, 32'd0);
    cyc_n(10);
    run = 1'b0;
    cyc_n(10);
    chk("s3_checked", checked_cnt, 32'd10);
    chk("s3_nonce_out", nonce_out, 32'h20A);
    chk("s3_kept_valid", {31'd0, gn_valid}, 32'd1);
    chk("s3_kept_nonce", gn_nonce, 32'h10A);
    gn_ready = 1'b1;
    cyc_n(1);
    gn_ready = 1'b0;
    chk("s3_drained", {31'd0, gn_valid}, 32'd0);
    chk("s3_pop_count", 32'(popped.size() - pb), 32'd1);
    chk("s3_pop0", popped[pb], 32'h10A);

    // Overflow, then push and pop together on a full FIFO.
    match_all = 1'b1;
    do_restart(32'h300);
    run = 1'b1;
    cyc_n(10);
    run = 1'b0;
    cyc_n(8);
    chk("s4_ovf", {24'd0, overflow_cnt}, 32'd6);
    chk("s4_head", gn_nonce, 32'h300);
    pb = popped.size();
    run = 1'b1;
    cyc_n(1);
    run = 1'b0;
    cyc_n(3);
    gn_ready = 1'b1;
    cyc_n(1);
    gn_ready = 1'b0;
    chk("s5_ovf", {24'd0, overflow_cnt}, 32'd6);
    chk("s5_head", gn_nonce, 32'h301);
    gn_ready = 1'b1;
    cyc_n(5);
    chk("s5_pop_count", 32'(popped.size() - pb), 32'd5);
    for (int i = 0; i < 4; i++) chk("s5_order", popped[pb+i], 32'h300 + 32'(i));
    chk("s5_last", popped[pb+4], 32'h30A);
    gn_ready = 1'b0;
    run = 1'b1;
    cyc_n(304);
    run = 1'b0;
    cyc_n(8);
    chk("s4_ovf_sat", {24'd0, overflow_cnt}, 32'd255);
    gn_ready = 1'b1;
    cyc_n(6);
    match_all = 1'b0;

    // Asynchronous reset mid-run.
    do_restart(32'h100);
    run = 1'b1;
    cyc_n(5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("s6_nonce_out", nonce_out, 32'd0);
    chk("s6_gn_valid", {31'd0, gn_valid}, 32'd0);
    chk("s6_gn_nonce", gn_nonce, 32'd0);
    chk("s6_ovf", {24'd0, overflow_cnt}, 32'd0);
    chk("s6_checked", checked_cnt, 32'd0);
    cyc_n(2);
    run = 1'b0;
    reset_n = 1'b1;
    cyc_n(2);
    scen_basic("s6");

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      run = ($urandom_range(3) != 0);
      gn_ready = $urandom_range(1);
      restart = ($urandom_range(29) == 0);
      if (restart) begin
        nonce_start = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : 32'h100 + $urandom_range(15);
        if ($urandom_range(3) == 0) match_all = ~match_all;
      end
      cyc_n(1);
    end
    restart = 1'b0;
    run = 1'b0;
    match_all = 1'b0;
    gn_ready = 1'b1;
    cyc_n(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
